// File: rtl/lsu_mem_ctrl.sv
// Load/store unit bridging the datapath memory port to a req/ack data memory.
// Steers store lanes, formats loads, checks alignment and times out the bus.
module lsu_mem_ctrl #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AccessErr,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_f3;
  logic [1:0]       r_lane;

  logic        w_access;
  logic        w_f3_ok;
  logic        w_align;
  logic        w_legal;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld;
  logic [1:0]  w_a;

  assign w_a       = Mem_WrAddr[1:0];
  assign w_access  = MemRead | MemWrite;
  assign w_timeout = (r_cnt == LAST);

  always_comb begin
    w_f3_ok = 1'b0;
    unique case (Funct3)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = MemRead;
      default:                w_f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_align = 1'b1;
    w_be    = 4'b1111;
    w_wdata = Mem_WrData;
    unique case (Funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_a;
        w_wdata = {4{Mem_WrData[7:0]}};
      end
      2'b01: begin
        w_align = ~w_a[0];
        w_be    = 4'b0011 << w_a;
        w_wdata = {2{Mem_WrData[15:0]}};
      end
      default: w_align = (w_a == 2'b00);
    endcase
  end

  assign w_legal = (MemRead ^ MemWrite) & w_f3_ok & w_align;

  assign w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
  assign w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_ld = mem_rdata;
    unique case (r_f3)
      3'b000:  w_ld = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ld = {24'd0, w_byte};
      3'b001:  w_ld = {{16{w_half[15]}}, w_half};
      3'b101:  w_ld = {16'd0, w_half};
      default: w_ld = mem_rdata;
    endcase
  end

  always_comb begin
    w_next = r_state;
    Stall  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_access && w_legal) begin
          w_next = S_REQ;
          Stall  = 1'b1;
        end
      end
      S_REQ: begin
        Stall = 1'b1;
        if (mem_ack || w_timeout) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ReadData  <= '0;
      AccessErr <= 1'b0;
      BusErr    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      r_cnt     <= '0;
      r_f3      <= '0;
      r_lane    <= '0;
    end else begin
      AccessErr <= 1'b0;
      BusErr    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_access && w_legal) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWrite;
            mem_addr  <= {Mem_WrAddr[31:2], 2'b00};
            mem_be    <= MemWrite ? w_be : 4'b1111;
            mem_wdata <= MemWrite ? w_wdata : 32'd0;
            r_f3      <= Funct3;
            r_lane    <= w_a;
            r_cnt     <= '0;
          end else if (w_access) begin
            AccessErr <= 1'b1;
            ReadData  <= '0;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // a late ack still wins over the timeout in the same cycle
          if (mem_ack) begin
            mem_req  <= 1'b0;
            ReadData <= mem_we ? 32'd0 : w_ld;
          end else if (w_timeout) begin
            mem_req  <= 1'b0;
            BusErr   <= 1'b1;
            ReadData <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
